serial_link_param: RTL and testbench
====================================

// Module: serial_link_param
// PURPOSE
//  Parametrised serial link: N channels of W bits each, loaded per channel and sent LSB-first over one wire.
//  Framing is start / data / optional even parity / stop.
//  TX and RX engines share one clock; the bench loops tx_line back to rx_line.
//  Successor to the fixed 4x4-bit TX/RX pair; adds a reset, a busy flag, parity and framing checks, and back-to-back frames.
// PARAMETERS
//  W          4   bits per channel
//  N          4   channel count
//  PARITY_EN  1   1 = even-parity bit appended after data; 0 = no parity bit
//  Frame length L = N*W + 2 + PARITY_EN bits (default 19)
// PORTS
//  clk         in   1    system clock, rising edge
//  rst         in   1    asynchronous reset, active-high
//  data_in     in   N*W  channel i is data_in[i*W +: W]
//  ld          in   N    ld[i] loads channel i holding register
//  transmit    in   1    frame request, level-sampled while TX idle
//  busy        out  1    TX frame in progress
//  tx_line     out  1    serial output, idle high, registered
//  rx_line     in   1    serial input
//  data_out    out  N*W  last good frame, same channel packing as data_in
//  received    out  1    1-cycle pulse: good frame stored
//  parity_err  out  1    1-cycle pulse: parity mismatch, frame dropped
//  frame_err   out  1    1-cycle pulse: stop bit was 0, frame dropped
// BEHAVIOUR
//  Reset (async): holding regs=0, tx_line=1, busy=0, data_out=0, received=parity_err=frame_err=0; both FSMs to IDLE.
//  Reset mid-frame aborts immediately; the partial RX frame is discarded.
//  Loading:
//   ld[i] at edge E -> holding reg i = data_in slice i.
//   Loading is allowed at any time, including while busy.
//  TX FSM: IDLE -> START -> DATA (N*W cycles) -> PARITY (only if PARITY_EN) -> STOP -> IDLE/START.
//   Frame accept: transmit=1 in IDLE at edge E0.
//    Holding regs are snapshotted into the shift register at E0, using pre-E0 contents.
//    A same-edge ld affects the next frame only.
//   Bit timing: frame bit k is driven on tx_line between E0+k and E0+k+1.
//    Order: start=0, data bit0 of ch0 first ... MSB of ch N-1 last, parity = XOR of data bits, stop=1.
//   busy=1 from E0 until the edge ending STOP.
//   Back-to-back: if transmit=1 at the STOP edge, go directly to START (new snapshot); there is no idle gap.
//  RX FSM: IDLE -> DATA -> PARITY (if PARITY_EN) -> STOP -> IDLE; WAIT_HIGH state for error recovery.
//   IDLE: rx_line=0 sampled at an edge = start bit.
//   Next N*W edges shift in data; then parity (if enabled); then stop.
//   At the stop-sample edge:
//    stop=0 -> frame_err=1, enter WAIT_HIGH.
//    else parity mismatch -> parity_err=1, enter IDLE.
//    else data_out <= shifted data, received=1, enter IDLE.
//    frame_err takes priority over parity_err; at most one status pulse per frame.
//   WAIT_HIGH: stay until rx_line=1 is sampled, then IDLE. A low line can never be taken as a start here.
//   data_out is held unchanged on any error.
//  Loopback latency: transmit sampled at E0 -> received high during cycle E0+L .. E0+L+1.
//   Default: 19 edges; 18 with PARITY_EN=0.
// TESTING
//  1. Assert rst mid-clock -> all outputs immediately at their reset values, without waiting for a clock edge.
//  2. Loopback, defaults.
//     Stimulus: ld channels 0..3 = 3,A,5,F; transmit for 1 cycle.
//     Response: busy high for 19 cycles; received pulse 19 edges after accept; data_out=16'hF5A3; no error pulses.
//     Repeat with PARITY_EN=0: received pulse after 18 edges.
//  3. Parity fault: invert rx_line during data bit 5 -> parity_err pulse, received=0, data_out keeps its previous value.
//  4. Framing fault.
//     Stimulus: force rx_line=0 during the stop bit and hold it low 3 extra cycles.
//     Response: frame_err pulse; no start detected until rx_line returns high; the next clean frame decodes correctly.
//  5. Back-to-back.
//     Stimulus: transmit held high for 2 frames; ld channel0=7 mid-frame 1.
//     Response: frame 1 data_out=16'hF5A3, frame 2 data_out=16'hF5A7; no idle gap between the frames.
//  6. Reset at data bit 7 -> tx_line=1 at once, no received pulse; a new frame after reset release decodes correctly.

Source files
------------

// File: rtl/serial_link_param.sv
// Parametrised N x W-bit serial link: per-channel holding registers, a framed LSB-first
// transmitter (start / data / optional even parity / stop) and a matching receiver.
module serial_link_param #(
   parameter int unsigned W         = 4,
   parameter int unsigned N         = 4,
   parameter int unsigned PARITY_EN = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N*W-1:0] data_in,
   input  logic [N-1:0] ld,
   input  logic         transmit,
   output logic         busy,
   output logic         tx_line,
   input  logic         rx_line,
   output logic [N*W-1:0] data_out,
   output logic         received,
   output logic         parity_err,
   output logic         frame_err
);

   localparam int unsigned NW = N * W;
   localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;
   localparam logic [CW-1:0] LastBit = CW'(NW - 1);
   localparam bit HasParity = (PARITY_EN != 0);

   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
   typedef enum logic [2:0] {RxIdle, RxData, RxParity, RxStop, RxWaitHigh} rx_state_e;

   // ------------------------------------------------------------------
   // Holding registers
   // ------------------------------------------------------------------
   logic [NW-1:0] hold_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (ld[i]) hold_q[i*W +: W] <= data_in[i*W +: W];
         end
      end
   end

   // ------------------------------------------------------------------
   // Transmitter: the state names the bit currently on tx_line
   // ------------------------------------------------------------------
   tx_state_e     tx_state_q, tx_state_d;
   logic [NW-1:0] tx_shift_q, tx_shift_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic          tx_par_q, tx_par_d;
   logic          tx_line_q, tx_line_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= TxIdle;
         tx_shift_q <= '0;
         tx_cnt_q   <= '0;
         tx_par_q   <= 1'b0;
         tx_line_q  <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_shift_q <= tx_shift_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_par_q   <= tx_par_d;
         tx_line_q  <= tx_line_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      tx_cnt_d   = tx_cnt_q;
      tx_par_d   = tx_par_q;
      tx_line_d  = tx_line_q;
      unique case (tx_state_q)
         TxIdle: begin
            tx_line_d = 1'b1;
            if (transmit) begin
               tx_state_d = TxStart;
               tx_shift_d = hold_q;
               tx_par_d   = ^hold_q;
               tx_line_d  = 1'b0;
            end
         end
         TxStart: begin
            tx_state_d = TxData;
            tx_cnt_d   = '0;
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
         end
         TxData: begin
            if (tx_cnt_q == LastBit) begin
               if (HasParity) begin
                  tx_state_d = TxParity;
                  tx_line_d  = tx_par_q;
               end else begin
                  tx_state_d = TxStop;
                  tx_line_d  = 1'b1;
               end
            end else begin
               tx_cnt_d   = tx_cnt_q + CW'(1);
               tx_line_d  = tx_shift_q[0];
               tx_shift_d = tx_shift_q >> 1;
            end
         end
         TxParity: begin
            tx_state_d = TxStop;
            tx_line_d  = 1'b1;
         end
         TxStop: begin
            // Back-to-back: the stop edge doubles as the next accept edge.
            if (transmit) begin
               tx_state_d = TxStart;
               tx_shift_d = hold_q;
               tx_par_d   = ^hold_q;
               tx_line_d  = 1'b0;
            end else begin
               tx_state_d = TxIdle;
               tx_line_d  = 1'b1;
            end
         end
         default: begin
            tx_state_d = TxIdle;
            tx_line_d  = 1'b1;
         end
      endcase
   end

   assign busy    = (tx_state_q != TxIdle);
   assign tx_line = tx_line_q;

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   rx_state_e     rx_state_q, rx_state_d;
   logic [NW-1:0] rx_shift_q, rx_shift_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic          rx_par_q, rx_par_d;
   logic [NW-1:0] data_out_q, data_out_d;
   logic          received_q, received_d;
   logic          parity_err_q, parity_err_d;
   logic          frame_err_q, frame_err_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_q   <= RxIdle;
         rx_shift_q   <= '0;
         rx_cnt_q     <= '0;
         rx_par_q     <= 1'b0;
         data_out_q   <= '0;
         received_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_state_q   <= rx_state_d;
         rx_shift_q   <= rx_shift_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_par_q     <= rx_par_d;
         data_out_q   <= data_out_d;
         received_q   <= received_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_comb begin
      rx_state_d   = rx_state_q;
      rx_shift_d   = rx_shift_q;
      rx_cnt_d     = rx_cnt_q;
      rx_par_d     = rx_par_q;
      data_out_d   = data_out_q;
      received_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            if (!rx_line) begin
               rx_state_d = RxData;
               rx_cnt_d   = '0;
            end
         end
         RxData: begin
            // LSB-first: each new bit enters at the top and moves down.
            rx_shift_d = NW'({rx_line, rx_shift_q} >> 1);
            rx_cnt_d   = rx_cnt_q + CW'(1);
            if (rx_cnt_q == LastBit) begin
               rx_state_d = HasParity ? RxParity : RxStop;
            end
         end
         RxParity: begin
            rx_par_d   = rx_line;
            rx_state_d = RxStop;
         end
         RxStop: begin
            if (!rx_line) begin
               frame_err_d = 1'b1;
               rx_state_d  = RxWaitHigh;
            end else if (HasParity && ((^rx_shift_q) != rx_par_q)) begin
               parity_err_d = 1'b1;
               rx_state_d   = RxIdle;
            end else begin
               data_out_d = rx_shift_q;
               received_d = 1'b1;
               rx_state_d = RxIdle;
            end
         end
         RxWaitHigh: begin
            // A stuck-low line must not be mistaken for a start bit.
            if (rx_line) rx_state_d = RxIdle;
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   assign data_out   = data_out_q;
   assign received   = received_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_serial_link_param.sv
// Directed loopback bench: default instance with fault injection on its rx_line, plus a
// PARITY_EN=0 instance looped back cleanly for the shorter-frame latency.
module tb_serial_link_param;

   logic        clk;
   logic        rst;
   logic [15:0] data_in;
   logic [3:0]  ld;
   logic        transmit;
   logic        rx_flip;
   logic        rx_ovr;

   logic        busy_a, tx_a, rx_a, rcv_a, perr_a, ferr_a;
   logic [15:0] dout_a;
   logic        busy_b, tx_b, rx_b, rcv_b, perr_b, ferr_b;
   logic [15:0] dout_b;

   int n_total = 0;
   int n_bad   = 0;

   int          rcv_at, rcv2_at, rcv_np_at, perr_at, ferr_at;
   int          busy_n, rcv_n, perr_n, ferr_n, np_err_n;
   logic [15:0] dat1, dat2, dat_np;

   assign rx_a = rx_ovr ? 1'b0 : (tx_a ^ rx_flip);
   assign rx_b = tx_b;

   serial_link_param dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .ld         (ld),
      .transmit   (transmit),
      .busy       (busy_a),
      .tx_line    (tx_a),
      .rx_line    (rx_a),
      .data_out   (dout_a),
      .received   (rcv_a),
      .parity_err (perr_a),
      .frame_err  (ferr_a)
   );

   serial_link_param #(.PARITY_EN(0)) dut_np (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .ld         (ld),
      .transmit   (transmit),
      .busy       (busy_b),
      .tx_line    (tx_b),
      .rx_line    (rx_b),
      .data_out   (dout_b),
      .received   (rcv_b),
      .parity_err (perr_b),
      .frame_err  (ferr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_all();
      ld = 4'hF;
      step();
      ld = 4'h0;
   endtask

   // Accept a frame at the next edge (k=0), then observe k = 0..steps after it.
   task automatic frame_watch(input int steps, input int flip_at, input int low_from,
                              input int low_to, input int tx_until, input int ld_at,
                              input logic [3:0] ld_val);
      rcv_at = -1; rcv2_at = -1; rcv_np_at = -1; perr_at = -1; ferr_at = -1;
      busy_n = 0; rcv_n = 0; perr_n = 0; ferr_n = 0; np_err_n = 0;
      dat1 = '0; dat2 = '0; dat_np = '0;
      transmit = 1'b1;
      step();
      for (int k = 0; k <= steps; k++) begin
         if (k > 0) step();
         if (busy_a) busy_n++;
         if (rcv_a) begin
            rcv_n++;
            if (rcv_at < 0) begin
               rcv_at = k;
               dat1   = dout_a;
            end else if (rcv2_at < 0) begin
               rcv2_at = k;
               dat2    = dout_a;
            end
         end
         if (perr_a) begin
            perr_n++;
            if (perr_at < 0) perr_at = k;
         end
         if (ferr_a) begin
            ferr_n++;
            if (ferr_at < 0) ferr_at = k;
         end
         if (rcv_b && rcv_np_at < 0) begin
            rcv_np_at = k;
            dat_np    = dout_b;
         end
         if (perr_b || ferr_b) np_err_n++;
         rx_flip  = (k == flip_at);
         rx_ovr   = (k >= low_from) && (k < low_to);
         transmit = (k + 1 < tx_until);
         if (k == ld_at) begin
            data_in[3:0] = ld_val;
            ld = 4'b0001;
         end else begin
            ld = 4'b0000;
         end
      end
      rx_flip  = 1'b0;
      rx_ovr   = 1'b0;
      transmit = 1'b0;
      ld       = 4'b0000;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; data_in = '0; ld = '0; transmit = 1'b0; rx_flip = 1'b0; rx_ovr = 1'b0;

      // Asynchronous reset, asserted between clock edges
      #1 rst = 1'b1;
      #1;
      check("rst tx_line", 32'(tx_a), 32'd1);
      check("rst busy", 32'(busy_a), 32'd0);
      check("rst data_out", 32'(dout_a), 32'h0);
      check("rst received", 32'(rcv_a), 32'd0);
      check("rst parity_err", 32'(perr_a), 32'd0);
      check("rst frame_err", 32'(ferr_a), 32'd0);
      step(); step();
      rst = 1'b0;
      step();

      // Clean loopback, both parity settings
      data_in = 16'hF5A3;
      load_all();
      frame_watch(25, -1, -1, -1, 1, -1, 4'h0);
      check("loop latency", 32'(rcv_at), 32'd19);
      check("loop data", 32'(dat1), 32'hF5A3);
      check("loop busy cycles", 32'(busy_n), 32'd19);
      check("loop pulses", 32'(rcv_n), 32'd1);
      check("loop perr", 32'(perr_n), 32'd0);
      check("loop ferr", 32'(ferr_n), 32'd0);
      check("np latency", 32'(rcv_np_at), 32'd18);
      check("np data", 32'(dat_np), 32'hF5A3);
      check("np errors", 32'(np_err_n), 32'd0);
      step(); step();

      // Parity fault: data bit 5 is frame bit 6, sampled at edge 7
      frame_watch(25, 6, -1, -1, 1, -1, 4'h0);
      check("par perr edge", 32'(perr_at), 32'd19);
      check("par received", 32'(rcv_n), 32'd0);
      check("par ferr", 32'(ferr_n), 32'd0);
      check("par data held", 32'(dout_a), 32'hF5A3);
      step(); step();

      // Framing fault: stop sample and 3 more held low
      frame_watch(30, -1, 18, 22, 1, -1, 4'h0);
      check("frm ferr edge", 32'(ferr_at), 32'd19);
      check("frm ferr count", 32'(ferr_n), 32'd1);
      check("frm perr", 32'(perr_n), 32'd0);
      check("frm received", 32'(rcv_n), 32'd0);
      check("frm data held", 32'(dout_a), 32'hF5A3);
      step(); step(); step();
      data_in[3:0] = 4'h1;
      ld = 4'b0001;
      step();
      ld = 4'b0000;
      frame_watch(25, -1, -1, -1, 1, -1, 4'h0);
      check("recover latency", 32'(rcv_at), 32'd19);
      check("recover data", 32'(dat1), 32'hF5A1);
      check("recover errors", 32'(perr_n + ferr_n), 32'd0);
      step(); step();

      // Back-to-back, channel 0 reloaded mid-frame 1
      data_in = 16'hF5A3;
      load_all();
      frame_watch(45, -1, -1, -1, 20, 5, 4'h7);
      check("b2b first edge", 32'(rcv_at), 32'd19);
      check("b2b first data", 32'(dat1), 32'hF5A3);
      check("b2b second edge", 32'(rcv2_at), 32'd38);
      check("b2b second data", 32'(dat2), 32'hF5A7);
      check("b2b busy cycles", 32'(busy_n), 32'd38);
      check("b2b errors", 32'(perr_n + ferr_n), 32'd0);
      step(); step();

      // Reset during data bit 7 (frame bit 8)
      transmit = 1'b1;
      step();
      transmit = 1'b0;
      repeat (8) step();
      check("pre-rst busy", 32'(busy_a), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid rst tx_line", 32'(tx_a), 32'd1);
      check("mid rst busy", 32'(busy_a), 32'd0);
      check("mid rst np busy", 32'(busy_b), 32'd0);
      check("mid rst data_out", 32'(dout_a), 32'h0);
      step();
      check("mid rst received", 32'(rcv_a), 32'd0);
      step();
      rst = 1'b0;
      data_in = 16'hF5A3;
      load_all();
      frame_watch(25, -1, -1, -1, 1, -1, 4'h0);
      check("post rst latency", 32'(rcv_at), 32'd19);
      check("post rst data", 32'(dat1), 32'hF5A3);
      check("post rst pulses", 32'(rcv_n), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
